// File: rtl/hist_pkg.sv
// Shared types and helpers for the multi-lane histogram engine.
`default_nettype none

package hist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int MAX_LANES     = 16;
    localparam int CNT_W_DEFAULT = 16;
    localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = '1;

    // Population count of the per-lane hit vector (lanes beyond LANES are zero-padded).
    function automatic logic [4:0] lane_match_count(input logic [MAX_LANES-1:0] hits);
        logic [4:0] n;
        n = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            n = n + 5'(hits[k]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hist_bin_cnt.sv
// One histogram bin: saturating counter that adds 0..LANES per cycle.
`default_nettype none

module hist_bin_cnt #(
    parameter int CNT_W = 16,
    parameter int INC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [SUM_W-1:0] MAX = SUM_W'({CNT_W{1'b1}});

    logic [SUM_W-1:0] sum;

    assign sum = SUM_W'(count) + SUM_W'(inc);
    assign sat = (sum > MAX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (sat) begin
            count <= '1;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/hist_vec_engine.sv
// Multi-lane histogram engine: streams LANES pixels per cycle from image memory
// into BINS saturating counters, with start/done control and a registered readout.
`default_nettype none

module hist_vec_engine
    import hist_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int PIX_W  = 8,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   clear_en,
    input  logic [ADDR_W-1:0]      img_base,
    input  logic [LEN_W-1:0]       img_len,
    output logic                   img_rd_en,
    output logic [ADDR_W-1:0]      img_rd_addr,
    input  logic [LANES*PIX_W-1:0] img_rd_data,
    input  logic [PIX_W-1:0]       rd_bin,
    output logic [CNT_W-1:0]       rd_count,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_flag
);

    localparam int BINS  = 2**PIX_W;
    localparam int LOG2L = $clog2(LANES);
    localparam int INC_W = $clog2(LANES+1);
    localparam logic [LEN_W:0] ONE_WORD = (LEN_W+1)'(1);

    state_t           state, state_nx;
    logic [LEN_W:0]   words_left, last_lanes;
    logic [LEN_W:0]   job_words, job_last;
    logic             start_ok, clear_bins;
    logic             acc_valid;
    logic [LANES-1:0] acc_mask, lane_mask;
    logic [CNT_W-1:0] bin_count [BINS];
    logic [BINS-1:0]  bin_sat;

    assign start_ok   = (state == IDLE) && start;
    assign clear_bins = (state == CLEAR);
    assign job_words  = ({1'b0, img_len} + (LEN_W+1)'(LANES-1)) >> LOG2L;
    assign job_last   = {1'b0, img_len} - ((job_words - 1'b1) << LOG2L);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = clear_en ? CLEAR : ((job_words == '0) ? DONE : FETCH);
            CLEAR:   state_nx = (words_left == '0) ? DONE : FETCH;
            FETCH:   if (words_left == ONE_WORD) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        img_rd_en = (state == FETCH);
    end

    // Only the final word can be partial; its valid lanes are held in last_lanes.
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_mask[k] = (words_left != ONE_WORD) || ((LEN_W+1)'(k) < last_lanes);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            img_rd_addr <= '0;
            words_left  <= '0;
            last_lanes  <= '0;
            acc_valid   <= 1'b0;
            acc_mask    <= '0;
            sat_flag    <= 1'b0;
            rd_count    <= '0;
        end else begin
            rd_count  <= bin_count[rd_bin];
            acc_valid <= (state == FETCH);
            acc_mask  <= lane_mask;
            if (start_ok) begin
                img_rd_addr <= img_base;
                words_left  <= job_words;
                last_lanes  <= job_last;
                sat_flag    <= 1'b0;
            end else begin
                if (state == FETCH) begin
                    img_rd_addr <= img_rd_addr + 1'b1;
                    words_left  <= words_left - 1'b1;
                end
                if (|bin_sat) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < BINS; b++) begin : g_bin
        logic [LANES-1:0] hit;
        logic [INC_W-1:0] inc;

        always_comb begin
            hit = '0;
            for (int k = 0; k < LANES; k++) begin
                hit[k] = acc_valid && acc_mask[k] && (img_rd_data[k*PIX_W +: PIX_W] == PIX_W'(b));
            end
        end

        assign inc = INC_W'(lane_match_count(MAX_LANES'(hit)));

        hist_bin_cnt #(
            .CNT_W(CNT_W),
            .INC_W(INC_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear_bins),
            .inc   (inc),
            .count (bin_count[b]),
            .sat   (bin_sat[b])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_hist_vec_engine.sv
// Self-checking bench for hist_vec_engine: table of jobs plus corner-case sequences.
`default_nettype none

module tb_hist_vec_engine;

    logic        clk = 1'b0;
    logic        reset, start, start_s, clear_en;
    logic [12:0] img_base;
    logic [15:0] img_len;
    logic [7:0]  rd_bin;
    logic        rd_en, rd_en_s;
    logic [12:0] rd_addr, rd_addr_s;
    logic [31:0] rdata, rdata_s;
    logic [15:0] rd_count;
    logic [3:0]  rd_count_s;
    logic        busy, done, sat, busy_s, done_s, sat_s;

    logic [31:0] mem [64];
    int          total_reads = 0;
    int          addr_log [1024];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    hist_vec_engine dut (
        .clk(clk), .reset(reset), .start(start), .clear_en(clear_en),
        .img_base(img_base), .img_len(img_len),
        .img_rd_en(rd_en), .img_rd_addr(rd_addr), .img_rd_data(rdata),
        .rd_bin(rd_bin), .rd_count(rd_count),
        .busy(busy), .done(done), .sat_flag(sat)
    );

    hist_vec_engine #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .clear_en(clear_en),
        .img_base(img_base), .img_len(img_len),
        .img_rd_en(rd_en_s), .img_rd_addr(rd_addr_s), .img_rd_data(rdata_s),
        .rd_bin(rd_bin), .rd_count(rd_count_s),
        .busy(busy_s), .done(done_s), .sat_flag(sat_s)
    );

    always @(posedge clk) begin
        if (rd_en)   rdata   <= mem[rd_addr[5:0]];
        if (rd_en_s) rdata_s <= mem[rd_addr_s[5:0]];
    end

    always @(posedge clk) begin
        if (rd_en) begin
            addr_log[total_reads % 1024] <= int'(rd_addr);
            total_reads                  <= total_reads + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input bit sel, input logic clr, input logic [12:0] base,
                           input logic [15:0] len, output int cycles);
        @(negedge clk);
        clear_en = clr;
        img_base = base;
        img_len  = len;
        if (sel) start_s = 1'b1; else start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_s = 1'b0;
        cycles  = 1;
        while (!(sel ? done_s : done) && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic read_bin(input logic [7:0] b, output int v, output int v_s);
        @(negedge clk);
        rd_bin = b;
        @(negedge clk);
        v   = int'(rd_count);
        v_s = int'(rd_count_s);
    endtask

    typedef struct {
        string       name;
        logic        clr;
        logic [12:0] base;
        logic [15:0] len;
        int          cycles;
        int          reads;
        int          first_addr;
        int          last_addr;
        logic [7:0]  bin_a;
        int          exp_a;
        logic [7:0]  bin_b;
        int          exp_b;
    } job_t;

    job_t jobs [8];

    initial begin
        int cyc, r0, nrd, v, vs;
        bit seen_done;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h01020304;
        mem[1]  = 32'h01010101;
        mem[10] = 32'h05060708;
        mem[11] = 32'h0B0B0909;
        mem[63] = 32'h02020202;
        for (int i = 20; i < 25; i++) mem[i] = 32'hFFFFFFFF;

        jobs[0] = '{"basic",      1'b1, 13'd0,    16'd8, 5, 2, 0,    1,  8'd1,  5,  8'd4,  1};
        jobs[1] = '{"accum",      1'b0, 13'd0,    16'd8, 4, 2, 0,    1,  8'd1,  10, 8'd4,  2};
        jobs[2] = '{"reclear",    1'b1, 13'd0,    16'd8, 5, 2, 0,    1,  8'd1,  5,  8'd2,  1};
        jobs[3] = '{"partial",    1'b1, 13'd10,   16'd6, 5, 2, 10,   11, 8'd9,  2,  8'd11, 0};
        jobs[4] = '{"partacc",    1'b0, 13'd10,   16'd6, 4, 2, 10,   11, 8'd9,  4,  8'd5,  2};
        jobs[5] = '{"zerolen",    1'b1, 13'd0,    16'd0, 2, 0, 0,    0,  8'd1,  0,  8'd9,  0};
        jobs[6] = '{"onelane",    1'b1, 13'd0,    16'd5, 5, 2, 0,    1,  8'd1,  2,  8'd4,  1};
        jobs[7] = '{"addrwrap",   1'b1, 13'd8191, 16'd8, 5, 2, 8191, 0,  8'd2,  5,  8'd1,  1};

        reset = 1'b1; start = 1'b0; start_s = 1'b0; clear_en = 1'b0;
        img_base = '0; img_len = '0; rd_bin = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",     int'(busy),     0);
        chk("reset_done",     int'(done),     0);
        chk("reset_sat",      int'(sat),      0);
        chk("reset_rd_en",    int'(rd_en),    0);
        chk("reset_rd_addr",  int'(rd_addr),  0);
        chk("reset_rd_count", int'(rd_count), 0);
        reset = 1'b0;

        foreach (jobs[i]) begin
            r0 = total_reads;
            run_job(1'b0, jobs[i].clr, jobs[i].base, jobs[i].len, cyc);
            chk({jobs[i].name, "_cycles"}, cyc, jobs[i].cycles);
            chk({jobs[i].name, "_sat"}, int'(sat), 0);
            @(negedge clk);
            chk({jobs[i].name, "_done_pulse"}, int'(done), 0);
            chk({jobs[i].name, "_idle"}, int'(busy), 0);
            nrd = total_reads - r0;
            chk({jobs[i].name, "_reads"}, nrd, jobs[i].reads);
            if (nrd > 0 && jobs[i].reads > 0) begin
                chk({jobs[i].name, "_first_addr"}, addr_log[r0 % 1024], jobs[i].first_addr);
                chk({jobs[i].name, "_last_addr"}, addr_log[(r0 + nrd - 1) % 1024], jobs[i].last_addr);
            end
            read_bin(jobs[i].bin_a, v, vs);
            chk({jobs[i].name, "_bin_a"}, v, jobs[i].exp_a);
            read_bin(jobs[i].bin_b, v, vs);
            chk({jobs[i].name, "_bin_b"}, v, jobs[i].exp_b);
        end

        // Saturation on the 4-bit-counter instance, then sticky flag cleared by next start.
        run_job(1'b1, 1'b1, 13'd20, 16'd20, cyc);
        chk("sat_cycles", cyc, 8);
        chk("sat_flag_set", int'(sat_s), 1);
        read_bin(8'hFF, v, vs);
        chk("sat_bin255", vs, 15);
        run_job(1'b1, 1'b0, 13'd0, 16'd0, cyc);
        chk("sat_nolen_cycles", cyc, 1);
        chk("sat_flag_cleared", int'(sat_s), 0);
        read_bin(8'hFF, v, vs);
        chk("sat_bin255_kept", vs, 15);

        // Start pulse during a busy job must be ignored.
        r0 = total_reads;
        @(negedge clk);
        clear_en = 1'b1; img_base = 13'd0; img_len = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clear_en = 1'b0; img_base = 13'd10; img_len = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_start_cycles", cyc, 5);
        @(negedge clk);
        chk("busy_start_idle", int'(busy), 0);
        chk("busy_start_reads", total_reads - r0, 2);
        read_bin(8'd1, v, vs);
        chk("busy_start_bin1", v, 5);

        // Reset asserted in FETCH aborts the job with no done pulse and clears bins.
        @(negedge clk);
        clear_en = 1'b0; img_base = 13'd0; img_len = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_in_fetch", int'(rd_en), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", int'(seen_done), 0);
        read_bin(8'd1, v, vs);
        chk("abort_bin1", v, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
